nibble_serial_adder_seq: RTL

- Sequencer that performs WIDTH-bit add/subtract by driving the team's 4-bit ripple_adder netlist one nibble per cycle.
- Registers the carry between nibbles and assembles the full-width result.
- Sits directly around the ripple adder: upstream it supplies A/B/ci, downstream it consumes SUM/co.
- Valid/ready handshakes on the operand and result sides.

---
 rtl/nibble_serial_adder_seq_pkg.sv | 17 +
 rtl/nibble_serial_adder_seq_if.sv | 27 ++
 rtl/nibble_serial_adder_seq_shift_reg.sv | 30 +++
 rtl/nibble_serial_adder_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_seq_pkg.sv
// Shared constants and types for the nibble-serial add/subtract sequencer.
// Defines the FSM state encoding and the counter width helper.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int count_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_seq_if.sv
// Operand request and result handshake bundle for the nibble-serial adder.
// The sequencer is the slave side; the requester/consumer is the master.
interface nibble_serial_adder_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/nibble_serial_adder_seq_shift_reg.sv
// Parallel-load register that shifts right by one nibble per step.
// Only the low nibble is exposed: it feeds the adder on each pass.
module nibble_shift_reg
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [WIDTH-1:0]    din,
    output logic [NIBBLE_W-1:0] nib
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> NIBBLE_W;
        end
    end

    assign nib = q[NIBBLE_W-1:0];

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// Drives an external 4-bit ripple adder one nibble per cycle to build a
// WIDTH-bit add/subtract result, with valid/ready on both sides.
module nibble_serial_adder_seq
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    nibble_serial_adder_seq_if.slave io,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_ci,
    input  logic [NIBBLE_W-1:0] add_sum,
    input  logic                add_co
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = count_w(NIBBLES);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t               state;
    logic [CW-1:0]        idx;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;
    logic [WIDTH-1:0]     res;
    logic [WIDTH+3:0]     res_cat;
    logic [WIDTH-1:0]     res_next;
    logic [WIDTH-1:0]     b_eff;
    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic                 accept;
    logic                 run;
    logic                 last;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_sum_q;
    logic                 out_cout_q;
    logic                 out_ovf_q;

    assign run      = (state == RUN);
    assign accept   = io.in_valid && (state == IDLE);
    assign b_eff    = io.in_sub ? ~io.in_b : io.in_b;
    assign last     = (idx == CW'(NIBBLES - 1));
    // Each pass drops its nibble in at the top; after NIBBLES passes
    // nibble 0 has migrated down to bits [3:0].
    assign res_cat  = {add_sum, res};
    assign res_next = res_cat[WIDTH+3:NIBBLE_W];

    nibble_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (run),
        .din   (io.in_a),
        .nib   (a_nib)
    );

    nibble_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (run),
        .din   (b_eff),
        .nib   (b_nib)
    );

    assign add_a  = run ? a_nib : '0;
    assign add_b  = run ? b_nib : '0;
    assign add_ci = run ? carry : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            res         <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        carry <= io.in_sub | io.in_cin;
                        a_msb <= io.in_a[WIDTH-1];
                        b_msb <= b_eff[WIDTH-1];
                        idx   <= '0;
                        res   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= add_co;
                    idx   <= idx + CW'(1);
                    if (last) begin
                        out_sum_q   <= res_next;
                        out_cout_q  <= add_co;
                        out_ovf_q   <= (a_msb == b_msb) &&
                                       (res_next[WIDTH-1] != a_msb);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_sum   = out_sum_q;
    assign io.out_cout  = out_cout_q;
    assign io.out_ovf   = out_ovf_q;

endmodule
